// File: rtl/axi_line_refill_if.sv
// AXI read-address and read-data channel bundle used by the line refill master.
interface axi_line_refill_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DATA_W = 64
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic [3:0]        arregion;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_line_refill.sv
// Cache-line refill master: one INCR burst per request, beats gathered into a
// line buffer and returned with a sticky error flag.
module axi_line_refill #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LINE_BEATS = 8,
  parameter int unsigned TXN_ID     = 0
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [ADDR_W-1:0]            req_addr_i,
  input  logic [2:0]                   req_prot_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [DATA_W*LINE_BEATS-1:0] rsp_line_o,
  output logic                         rsp_err_o,
  axi_line_refill_if.master            axi
);
  localparam int unsigned LINE_W     = DATA_W * LINE_BEATS;
  localparam int unsigned LINE_BYTES = (DATA_W / 8) * LINE_BEATS;
  localparam int unsigned CNT_W      = $clog2(LINE_BEATS) + 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [2:0]        arprot_q, arprot_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [1:0]        arburst_q, arburst_d;
  logic [3:0]        arcache_q, arcache_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic ar_hs, r_hs;
  assign ar_hs = arvalid_q & axi.arready;
  assign r_hs  = rready_q & axi.rvalid;

  // Next-state, AR field capture and beat collection
  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    arprot_d    = arprot_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    arcache_d   = arcache_q;
    arid_d      = arid_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    line_d      = line_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          araddr_d  = req_addr_i & LINE_MASK;
          arprot_d  = req_prot_i;
          arlen_d   = 8'(LINE_BEATS - 1);
          arsize_d  = 3'($clog2(DATA_W / 8));
          arburst_d = 2'b01;
          arcache_d = 4'b0011;
          arid_d    = ID_W'(TXN_ID);
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ar_hs) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (r_hs) begin
          if (axi.rresp != 2'b00 || axi.rid != ID_W'(TXN_ID)) err_d = 1'b1;
          // A beat past the end of the line is dropped and the counter holds
          if (cnt_q == CNT_W'(LINE_BEATS)) begin
            err_d = 1'b1;
          end else begin
            for (int unsigned b = 0; b < LINE_BEATS; b++) begin
              if (cnt_q == CNT_W'(b)) line_d[b*DATA_W +: DATA_W] = axi.rdata;
            end
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (axi.rlast) begin
            if (cnt_q != CNT_W'(LINE_BEATS - 1)) err_d = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    arvalid_d   = (state_d == S_ADDR);
    rready_d    = (state_d == S_DATA);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      araddr_q    <= '0;
      arprot_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
      arcache_q   <= '0;
      arid_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      araddr_q    <= araddr_d;
      arprot_q    <= arprot_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
      arcache_q   <= arcache_d;
      arid_q      <= arid_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      line_q      <= line_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_line_o   = line_q;
  assign rsp_err_o    = err_q;

  assign axi.arid     = arid_q;
  assign axi.araddr   = araddr_q;
  assign axi.arlen    = arlen_q;
  assign axi.arsize   = arsize_q;
  assign axi.arburst  = arburst_q;
  assign axi.arlock   = 1'b0;
  assign axi.arcache  = arcache_q;
  assign axi.arprot   = arprot_q;
  assign axi.arqos    = 4'b0000;
  assign axi.arregion = 4'b0000;
  assign axi.arvalid  = arvalid_q;
  assign axi.rready   = rready_q;
endmodule

// File: tb/tb_axi_line_refill.sv
// Bench for axi_line_refill: directed refills against a line/error model built
// from observed handshakes, plus literal checks of the key results.
module tb_axi_line_refill;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BEATS  = 8;

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [2:0]        req_prot = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W*BEATS-1:0] rsp_line;
  logic              rsp_err;

  axi_line_refill_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

  axi_line_refill #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W), .LINE_BEATS(BEATS), .TXN_ID(0)
  ) dut (
    .clk_i(clk), .arst_i(arst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_prot_i(req_prot),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_line_o(rsp_line), .rsp_err_o(rsp_err),
    .axi(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sl(input int k);
    return rsp_line[k*DATA_W +: DATA_W];
  endfunction

  // Model: line contents and error from the rules, driven by observed handshakes
  logic [63:0]       mline [BEATS];
  logic              merr = 1'b0;
  int                mk = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [2:0]        m_prot = '0;
  int                n_ar = 0;
  int                n_beats = 0;
  logic              ar_pend = 1'b0;
  logic              rsp_pend = 1'b0;
  logic [ADDR_W-1:0] prev_araddr = '0;
  logic [DATA_W*BEATS-1:0] prev_line = '0;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < BEATS; k++) mline[k] <= '0;
      merr     <= 1'b0;
      mk       <= 0;
      ar_pend  <= 1'b0;
      rsp_pend <= 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        m_addr <= (req_addr / 64) * 64;
        m_prot <= req_prot;
      end
      if (bus.arvalid && bus.arready) begin
        merr <= 1'b0;
        mk   <= 0;
        n_ar <= n_ar + 1;
      end
      if (bus.rvalid && bus.rready) begin
        if (bus.rresp != 2'b00 || bus.rid != 0 || (bus.rlast && mk != BEATS - 1) || mk >= BEATS)
          merr <= 1'b1;
        if (mk < BEATS) begin
          mline[mk] <= bus.rdata;
          mk <= mk + 1;
        end
        n_beats <= n_beats + 1;
      end
      ar_pend     <= bus.arvalid && !bus.arready;
      rsp_pend    <= rsp_valid && !rsp_ready;
      prev_araddr <= bus.araddr;
      prev_line   <= rsp_line;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!arst) begin
      if (bus.arvalid) begin
        chk("araddr", 64'(bus.araddr), 64'(m_addr));
        chk("arprot", 64'(bus.arprot), 64'(m_prot));
        chk("arlen", 64'(bus.arlen), 64'd7);
        chk("arsize", 64'(bus.arsize), 64'd3);
        chk("arburst", 64'(bus.arburst), 64'd1);
        chk("arid", 64'(bus.arid), 64'd0);
        chk("arcache", 64'(bus.arcache), 64'd3);
        chk("arlock_qos_region", 64'({bus.arlock, bus.arqos, bus.arregion}), 64'd0);
        chk("ar_r_excl", 64'(bus.rready), 64'd0);
      end
      if (ar_pend) begin
        chk("arvalid_hold", 64'(bus.arvalid), 64'd1);
        chk("araddr_hold", 64'(bus.araddr), 64'(prev_araddr));
      end
      if (rsp_valid) begin
        for (int k = 0; k < BEATS; k++) chk("rsp_line_model", sl(k), mline[k]);
        chk("rsp_err_model", 64'(rsp_err), 64'(merr));
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        chk("rready_in_resp", 64'(bus.rready), 64'd0);
      end
      if (rsp_pend) begin
        chk("rsp_valid_hold", 64'(rsp_valid), 64'd1);
        chk("rsp_line_hold", 64'(rsp_line == prev_line), 64'd1);
      end
    end
  end

  task automatic do_req(input logic [ADDR_W-1:0] a, input logic [2:0] p);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_prot = p;
    while (!req_ready) begin
      @(negedge clk);
      if (++t > 50) begin chk("req_timeout", 64'd0, 64'd1); req_valid = 1'b0; return; end
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ar_latency", 64'(bus.arvalid), 64'd1);
    chk("req_ready_after_accept", 64'(req_ready), 64'd0);
  endtask

  task automatic ar_accept(input int stall);
    int t = 0;
    while (!bus.arvalid) begin
      @(negedge clk);
      if (++t > 50) begin chk("ar_timeout", 64'd0, 64'd1); return; end
    end
    repeat (stall) @(negedge clk);
    chk("arvalid_after_stall", 64'(bus.arvalid), 64'd1);
    bus.arready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.arready = 1'b0;
  endtask

  task automatic send_r(input int n, input int last_idx, input int err_idx, input int id_idx,
                        input int base, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      int g;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      bus.rvalid = 1'b0;
      repeat (g) @(negedge clk);
      bus.rvalid = 1'b1;
      bus.rdata  = 64'(base + i);
      bus.rresp  = (i == err_idx) ? 2'b10 : 2'b00;
      bus.rid    = (i == id_idx) ? 4'h1 : 4'h0;
      bus.rlast  = (i == last_idx);
      t = 0;
      while (!bus.rready) begin
        @(negedge clk);
        if (++t > 50) begin chk("r_timeout", 64'd0, 64'd1); bus.rvalid = 1'b0; return; end
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00; bus.rid = '0;
  endtask

  task automatic wait_rsp();
    int t = 0;
    while (!rsp_valid) begin
      @(negedge clk);
      if (++t > 50) begin chk("rsp_timeout", 64'd0, 64'd1); return; end
    end
  endtask

  task automatic release_rsp(input int stall);
    repeat (stall) begin
      chk("req_ready_stall", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("req_ready_after_rsp", 64'(req_ready), 64'd1);
    chk("rsp_valid_dropped", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int ar0, b0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    bus.rresp = 2'b00; bus.rlast = 1'b0; bus.rid = '0;

    // Reset values
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_arvalid", 64'(bus.arvalid), 64'd0);
    chk("rst_rready", 64'(bus.rready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_araddr", 64'(bus.araddr), 64'd0);
    chk("rst_arlen", 64'(bus.arlen), 64'd0);
    chk("rst_line", 64'(rsp_line == '0), 64'd1);
    arst = 1'b0;
    @(negedge clk);
    chk("req_ready_post_rst", 64'(req_ready), 64'd1);

    // Basic refill
    ar0 = n_ar;
    do_req(32'h8000_1234, 3'b010);
    chk("basic_araddr", 64'(bus.araddr), 64'h8000_1200);
    chk("basic_arlen", 64'(bus.arlen), 64'd7);
    chk("basic_arsize", 64'(bus.arsize), 64'd3);
    chk("basic_arburst", 64'(bus.arburst), 64'd1);
    ar_accept(0);
    send_r(8, 7, -1, -1, 'h0, 1'b0);
    wait_rsp();
    for (int k = 0; k < BEATS; k++) chk("basic_slice", sl(k), 64'(k));
    chk("basic_err", 64'(rsp_err), 64'd0);
    release_rsp(0);
    chk("basic_one_ar", 64'(n_ar - ar0), 64'd1);

    // AR backpressure
    ar0 = n_ar;
    do_req(32'h0000_407F, 3'b000);
    chk("bp_araddr", 64'(bus.araddr), 64'h0000_4040);
    ar_accept(5);
    send_r(8, 7, -1, -1, 'h100, 1'b0);
    wait_rsp();
    chk("bp_slice0", sl(0), 64'h100);
    chk("bp_slice7", sl(7), 64'h107);
    chk("bp_err", 64'(rsp_err), 64'd0);
    release_rsp(0);
    chk("bp_one_ar", 64'(n_ar - ar0), 64'd1);

    // SLVERR on beat 3
    b0 = n_beats;
    do_req(32'h0000_2000, 3'b001);
    ar_accept(0);
    send_r(8, 7, 3, -1, 'h200, 1'b0);
    wait_rsp();
    chk("slverr_err", 64'(rsp_err), 64'd1);
    chk("slverr_slice3", sl(3), 64'h203);
    chk("slverr_slice4", sl(4), 64'h204);
    chk("slverr_beats", 64'(n_beats - b0), 64'd8);
    release_rsp(0);

    // Wrong rid on beat 1
    do_req(32'h0000_3008, 3'b000);
    ar_accept(0);
    send_r(8, 7, -1, 1, 'h280, 1'b0);
    wait_rsp();
    chk("rid_err", 64'(rsp_err), 64'd1);
    chk("rid_slice1", sl(1), 64'h281);
    release_rsp(0);

    // Early rlast on beat 5: slots 6 and 7 keep the previous line
    b0 = n_beats;
    do_req(32'h0000_5000, 3'b000);
    ar_accept(0);
    send_r(6, 5, -1, -1, 'h300, 1'b0);
    wait_rsp();
    chk("early_err", 64'(rsp_err), 64'd1);
    chk("early_slice5", sl(5), 64'h305);
    chk("early_slice6_stale", sl(6), 64'h286);
    chk("early_beats", 64'(n_beats - b0), 64'd6);
    release_rsp(0);

    // Missing rlast: ninth beat carries rlast and is discarded
    do_req(32'h0000_6010, 3'b000);
    ar_accept(0);
    send_r(9, 8, -1, -1, 'h400, 1'b0);
    wait_rsp();
    chk("missing_err", 64'(rsp_err), 64'd1);
    chk("missing_slice7", sl(7), 64'h407);
    chk("missing_slice0", sl(0), 64'h400);
    release_rsp(0);

    // R gaps and response stall
    do_req(32'h0000_7000, 3'b100);
    ar_accept(1);
    send_r(8, 7, -1, -1, 'h500, 1'b1);
    wait_rsp();
    chk("stall_slice2", sl(2), 64'h502);
    chk("stall_err", 64'(rsp_err), 64'd0);
    release_rsp(4);

    // Async reset mid-burst after 3 beats
    do_req(32'h1000_0010, 3'b000);
    ar_accept(0);
    send_r(3, -1, -1, -1, 'h600, 1'b0);
    #2 arst = 1'b1;
    #1;
    chk("arst_arvalid", 64'(bus.arvalid), 64'd0);
    chk("arst_rready", 64'(bus.rready), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    chk("arst_line", 64'(rsp_line == '0), 64'd1);
    repeat (2) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    chk("arst_release_ready", 64'(req_ready), 64'd1);
    chk("arst_release_err", 64'(rsp_err), 64'd0);

    // Fresh burst after reset
    ar0 = n_ar;
    do_req(32'h2222_22A8, 3'b011);
    chk("fresh_araddr", 64'(bus.araddr), 64'h2222_2280);
    ar_accept(2);
    send_r(8, 7, -1, -1, 'h700, 1'b1);
    wait_rsp();
    for (int k = 0; k < BEATS; k++) chk("fresh_slice", sl(k), 64'(32'h700 + k));
    chk("fresh_err", 64'(rsp_err), 64'd0);
    release_rsp(1);
    chk("fresh_one_ar", 64'(n_ar - ar0), 64'd1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
